mem_responder: RTL and testbench

- Word-organised, synthesizable memory responder: the slave end of the multicycle datapath's mem_read / mem_write / mem_resp handshake.
- Serves instruction fetch, load and store requests from the RV32I control/datapath with a fixed, parameterised latency.
- Applies per-byte write enables; used as on-chip RAM and as the memory model in core-level benches.

---
 rtl/mem_responder_pkg.sv | 15 +
 rtl/rv32i_types.sv | 8 +
 rtl/mem_responder_if.sv | 37 +++
 rtl/mem_responder_bytewise_ram.sv | 33 +++
 rtl/mem_responder.sv | 153 +++++++++++++++
 tb/tb_mem_responder.sv | 286 ++++++++++++++++++++++++++++
 6 files changed

// File: rtl/mem_responder_pkg.sv
// Types for the memory responder FSM.
// State enum and latency counter type.
package mem_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

  typedef logic [3:0] cnt_t;

  localparam int unsigned LAT_MAX = 15;

endpackage

// File: rtl/rv32i_types.sv
// Shared RV32I datapath types.
// Word and byte-mask types used on the memory bus.
package rv32i_types;

  typedef logic [31:0] rv32i_word;
  typedef logic [3:0]  rv32i_mem_wmask;

endpackage

// File: rtl/mem_responder_if.sv
// mem_read / mem_write / mem_resp bus.
// master: initiator side, slave: memory side.
interface mem_responder_if;
  import rv32i_types::*;

  logic           mem_read;
  logic           mem_write;
  rv32i_word      mem_address;
  rv32i_word      mem_wdata;
  rv32i_mem_wmask mem_byte_enable;
  rv32i_word      mem_rdata;
  logic           mem_resp;
  logic           mem_err;

  modport master (
    output mem_read,
    output mem_write,
    output mem_address,
    output mem_wdata,
    output mem_byte_enable,
    input  mem_rdata,
    input  mem_resp,
    input  mem_err
  );

  modport slave (
    input  mem_read,
    input  mem_write,
    input  mem_address,
    input  mem_wdata,
    input  mem_byte_enable,
    output mem_rdata,
    output mem_resp,
    output mem_err
  );

endinterface

// File: rtl/mem_responder_bytewise_ram.sv
// Single-port RAM of four 8-bit lanes, 2^ADDR_WIDTH deep.
// Ports: clk, en, we, addr, wmask, wdata in; rdata out (registered).
module bytewise_ram
  import rv32i_types::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  en,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  rv32i_mem_wmask        wmask,
  input  rv32i_word             wdata,
  output rv32i_word             rdata
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  for (genvar i = 0; i < 4; i++) begin : g_lane
    logic [7:0] arr [DEPTH];
    logic [7:0] q;

    always_ff @(posedge clk) begin
      if (en && we && wmask[i])
        arr[addr] <= wdata[8*i +: 8];
      if (en && !we)
        q <= arr[addr];
    end

    assign rdata[8*i +: 8] = q;
  end

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder (slave end of the mem bus).
// Ports: clk, rst (sync, active-high), bus (mem_responder_if.slave).
module mem_responder
  import mem_resp_pkg::*;
  import rv32i_types::*;
#(
  parameter int        ADDR_WIDTH = 10,
  parameter rv32i_word BASE_ADDR  = 32'h0000_0000,
  parameter int        LATENCY    = 3
) (
  input  logic            clk,
  input  logic            rst,
  mem_responder_if.slave  bus
);

  if (LATENCY < 1 || LATENCY > int'(LAT_MAX)) begin : g_bad_lat
    $error("mem_responder: LATENCY must be 1..15");
  end

  if (BASE_ADDR[1:0] != 2'b00) begin : g_bad_base
    $error("mem_responder: BASE_ADDR must be word aligned");
  end

  localparam logic [32:0] SPAN  = 33'd4 << ADDR_WIDTH;
  localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + SPAN;

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;

  logic           req_rd_q, req_wr_q;
  rv32i_word      req_addr_q, req_wdata_q;
  rv32i_mem_wmask req_be_q;

  logic err_q;
  logic zero_q;

  logic           idle, req_in;
  logic           acc_rd, acc_wr;
  rv32i_word      acc_addr, acc_wdata;
  rv32i_mem_wmask acc_be;
  rv32i_word      acc_word;
  logic           in_range, acc_err;
  logic           commit;
  logic [ADDR_WIDTH-1:0] idx;
  rv32i_word      ram_q;

  assign idle   = (state_q == IDLE);
  assign req_in = bus.mem_read | bus.mem_write;

  // With LATENCY==1 the commit edge is also the
  // acceptance edge, so the live bus feeds the access.
  always_comb begin
    acc_rd    = req_rd_q;
    acc_wr    = req_wr_q;
    acc_addr  = req_addr_q;
    acc_wdata = req_wdata_q;
    acc_be    = req_be_q;
    if (idle) begin
      acc_rd    = bus.mem_read;
      acc_wr    = bus.mem_write;
      acc_addr  = bus.mem_address;
      acc_wdata = bus.mem_wdata;
      acc_be    = bus.mem_byte_enable;
    end
  end

  assign acc_word = {acc_addr[31:2], 2'b00};

  // 33-bit compare so the window end cannot wrap.
  assign in_range =
    ({1'b0, acc_word} >= {1'b0, BASE_ADDR}) &&
    ({1'b0, acc_word} < LIMIT);

  assign acc_err = (acc_rd & acc_wr) | ~in_range;

  assign idx =
    ADDR_WIDTH'((acc_word - BASE_ADDR) >> 2);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (req_in) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            cnt_d   = cnt_t'(LATENCY - 2);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == '0)
          state_d = RESP;
        else
          cnt_d = cnt_q - cnt_t'(1);
      end
      RESP: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Access happens on the edge entering RESP; a reset
  // on that edge drops it.
  assign commit = (state_d == RESP) && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (commit) begin
        err_q <= acc_err;
        if (acc_rd && !acc_wr)
          zero_q <= ~in_range;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (idle && req_in) begin
      req_rd_q    <= bus.mem_read;
      req_wr_q    <= bus.mem_write;
      req_addr_q  <= bus.mem_address;
      req_wdata_q <= bus.mem_wdata;
      req_be_q    <= bus.mem_byte_enable;
    end
  end

  bytewise_ram #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .en    (commit & ~acc_err),
    .we    (acc_wr),
    .addr  (idx),
    .wmask (acc_be),
    .wdata (acc_wdata),
    .rdata (ram_q)
  );

  // RAM output only moves on a good read; zero_q
  // covers reset and out-of-range reads.
  assign bus.mem_rdata = zero_q ? '0 : ram_q;
  assign bus.mem_resp  = (state_q == RESP);
  assign bus.mem_err   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder.
// u0: AW=10 base 0 lat 3; u1: AW=4 base 0x100 lat 1.
module tb_mem_responder;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mem_responder_if m0 ();
  mem_responder_if m1 ();

  mem_responder #(
    .ADDR_WIDTH (10),
    .BASE_ADDR  (32'h0000_0000),
    .LATENCY    (3)
  ) u0 (
    .clk (clk),
    .rst (rst),
    .bus (m0)
  );

  mem_responder #(
    .ADDR_WIDTH (4),
    .BASE_ADDR  (32'h0000_0100),
    .LATENCY    (1)
  ) u1 (
    .clk (clk),
    .rst (rst),
    .bus (m1)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [16];
  logic [31:0] last0 = '0;
  logic [31:0] last1 = '0;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, want);
    end
  endtask

  task automatic mon(int d, logic [31:0] rd,
                     logic err);
    exp_t e;
    if ((d == 0 && q0.size() == 0) ||
        (d == 1 && q1.size() == 0)) begin
      total++;
      bad++;
      $display("FAIL u%0d spurious resp at cyc %0d",
               d, cyc);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("u%0d err", d), {31'b0, err},
        {31'b0, e.err});
    chk($sformatf("u%0d rdata", d), rd, e.rdata);
    chk($sformatf("u%0d resp cyc", d), cyc, e.cyc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (m0.mem_resp)
        mon(0, m0.mem_rdata, m0.mem_err);
      else if (m0.mem_err)
        chk("u0 stray err", {31'b0, m0.mem_err}, 0);
      if (m1.mem_resp)
        mon(1, m1.mem_rdata, m1.mem_err);
      else if (m1.mem_err)
        chk("u1 stray err", {31'b0, m1.mem_err}, 0);
    end
  end

  task automatic drive(int d, bit rd, bit wr,
                       logic [31:0] a, logic [31:0] wd,
                       logic [3:0] be);
    if (d == 0) begin
      m0.mem_read        = rd;
      m0.mem_write       = wr;
      m0.mem_address     = a;
      m0.mem_wdata       = wd;
      m0.mem_byte_enable = be;
    end else begin
      m1.mem_read        = rd;
      m1.mem_write       = wr;
      m1.mem_address     = a;
      m1.mem_wdata       = wd;
      m1.mem_byte_enable = be;
    end
  endtask

  function automatic bit resp_of(int d);
    return (d == 0) ? m0.mem_resp : m1.mem_resp;
  endfunction

  // Reference: flat word array, plain address math.
  task automatic issue(int d, bit rd, bit wr,
                       logic [31:0] a, logic [31:0] wd,
                       logic [3:0] be, bit hold);
    exp_t        e;
    longint      base, span, wa;
    int          ix;
    bit          inr, got;
    logic [31:0] last, w;
    base = (d == 0) ? 0 : 'h100;
    span = (d == 0) ? 4096 : 64;
    wa   = {32'b0, a[31:2], 2'b00};
    inr  = (wa >= base) && (wa < base + span);
    ix   = inr ? int'((wa - base) / 4) : 0;
    last = (d == 0) ? last0 : last1;
    w    = (d == 0) ? mem0[ix] : mem1[ix];
    if (rd && !wr)
      last = inr ? w : 32'h0;
    if (wr && !rd && inr) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) w[8*b +: 8] = wd[8*b +: 8];
      if (d == 0) mem0[ix] = w;
      else        mem1[ix] = w;
    end
    if (d == 0) last0 = last;
    else        last1 = last;
    e.err   = (rd && wr) || !inr;
    e.rdata = last;
    @(posedge clk);
    #1;
    drive(d, rd, wr, a, wd, be);
    e.cyc = cyc + ((d == 0) ? 3 : 1);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
    if (!hold) begin
      @(posedge clk);
      #1;
      drive(d, 0, 0, '0, '0, '0);
    end
    got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (resp_of(d)) got = 1;
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL u%0d timeout addr %h", d, a);
      if (d == 0) void'(q0.pop_back());
      else        void'(q1.pop_back());
    end
    @(posedge clk);
    #1;
    drive(d, 0, 0, '0, '0, '0);
  endtask

  function automatic logic [31:0] addr0();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0: a = 32'h1000 + $urandom_range(0, 255);
      1: a = 32'h0000_0FFC;
      2: a = $urandom | 32'h8000_0000;
      default: a = {$urandom_range(0, 15), 2'b00}
                   | $urandom_range(0, 3);
    endcase
    return a;
  endfunction

  function automatic logic [31:0] addr1();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0: a = 32'h0000_00FC + $urandom_range(0, 3);
      1: a = 32'h0000_0140 + $urandom_range(0, 3);
      default: a = 32'h100
                   + {$urandom_range(0, 15), 2'b00}
                   + $urandom_range(0, 3);
    endcase
    return a;
  endfunction

  task automatic rand_txn(int d);
    int          r;
    bit          rd, wr;
    logic [31:0] a;
    r  = $urandom_range(0, 19);
    rd = (r < 9) || (r >= 18);
    wr = (r >= 9);
    a  = (d == 0) ? addr0() : addr1();
    issue(d, rd, wr, a, $urandom,
          4'($urandom_range(0, 15)),
          bit'($urandom_range(0, 1)));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(0, 0, 0, '0, '0, '0);
    drive(1, 0, 0, '0, '0, '0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("u0 reset resp", {31'b0, m0.mem_resp}, 0);
    chk("u0 reset err", {31'b0, m0.mem_err}, 0);
    chk("u0 reset rdata", m0.mem_rdata, 0);
    chk("u1 reset resp", {31'b0, m1.mem_resp}, 0);
    chk("u1 reset err", {31'b0, m1.mem_err}, 0);
    chk("u1 reset rdata", m1.mem_rdata, 0);

    for (int i = 0; i < 16; i++)
      issue(0, 0, 1, 32'(i * 4), $urandom, 4'hF, 1);
    issue(0, 0, 1, 32'h0FFC, $urandom, 4'hF, 0);
    for (int i = 0; i < 16; i++)
      issue(1, 0, 1, 32'(256 + i * 4), $urandom,
            4'hF, 1);

    issue(0, 0, 1, 32'h10, 32'hCAFE_F00D, 4'hF, 1);
    issue(0, 1, 0, 32'h10, '0, '0, 1);
    chk("t1 readback", m0.mem_rdata, 32'hCAFE_F00D);
    issue(0, 0, 1, 32'h10, 32'h0000_00AA, 4'h1, 1);
    issue(0, 1, 0, 32'h10, '0, '0, 1);
    chk("t2 lane0", m0.mem_rdata, 32'hCAFE_F0AA);
    issue(0, 0, 1, 32'h10, 32'hFFFF_FFFF, 4'h0, 1);
    issue(0, 1, 0, 32'h10, '0, '0, 0);
    chk("t2 be0", m0.mem_rdata, 32'hCAFE_F0AA);

    issue(0, 1, 1, 32'h10, 32'h1234_5678, 4'hF, 1);
    chk("t6 rdata held", m0.mem_rdata, 32'hCAFE_F0AA);
    issue(0, 1, 0, 32'h1000, '0, '0, 1);
    chk("t5 oor rdata", m0.mem_rdata, 32'h0);
    issue(0, 1, 0, 32'h10, '0, '0, 1);
    chk("t6 no write", m0.mem_rdata, 32'hCAFE_F0AA);

    for (int i = 0; i < 6; i++)
      issue(1, 1, 0, 32'(256 + i * 4), '0, '0, 1);

    @(posedge clk);
    #1;
    drive(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 4'hF);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    drive(0, 0, 0, '0, '0, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    last0 = '0;
    last1 = '0;
    @(negedge clk);
    chk("t4 rdata after rst", m0.mem_rdata, 0);
    chk("t4 u1 rdata after rst", m1.mem_rdata, 0);
    repeat (4) @(negedge clk);
    issue(0, 1, 0, 32'h10, '0, '0, 1);
    chk("t4 old value", m0.mem_rdata, 32'hCAFE_F0AA);

    for (int i = 0; i < 150; i++) rand_txn(0);
    for (int i = 0; i < 150; i++) rand_txn(1);

    repeat (8) @(negedge clk);
    chk("u0 queue drained", q0.size(), 0);
    chk("u1 queue drained", q1.size(), 0);
    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end

endmodule
